keccak_squeeze_serializer: RTL and testbench

KECCAK_SQUEEZE_SERIALIZER -- requirements
Module: keccak_squeeze_serializer

---
 rtl/keccak_squeeze_serializer.sv | 91 +++++++++
 tb/tb_keccak_squeeze_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_serializer.sv
// Squeeze-phase serializer for a Keccak sponge: streams rate lanes as 64-bit words
// and requests a permutation whenever the rate portion of the state is used up.
module keccak_squeeze_serializer #(
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len,
  input  logic [1599:0]    state_in,
  output logic             perm_req,
  input  logic             perm_done,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int LANE_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {IDLE, EMIT, PERM} state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [LANE_W-1:0] lane_idx;
  logic [4:0]        lane_sel;
  logic              handshake;

  // Lane index widened to the 25-lane address space so it can drive the state mux.
  assign lane_sel   = 5'(lane_idx);
  assign dout_valid = (state == EMIT);
  assign perm_req   = (state == PERM);
  assign busy       = (state != IDLE);
  assign handshake  = dout_valid && dout_ready;
  assign last       = dout_valid && (remaining == LEN_W'(1));
  assign dout       = dout_valid ? state_in[{lane_sel, 6'd0} +: 64] : 64'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      lane_idx  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (out_len == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= out_len;
              lane_idx  <= '0;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (handshake) begin
            // Finishing the squeeze wins over wrapping into a permutation.
            if (remaining == LEN_W'(1)) begin
              remaining <= '0;
              lane_idx  <= '0;
              state     <= IDLE;
              done      <= 1'b1;
            end else begin
              remaining <= remaining - LEN_W'(1);
              if (lane_idx == LAST_LANE) begin
                lane_idx <= '0;
                state    <= PERM;
              end else begin
                lane_idx <= lane_idx + LANE_W'(1);
              end
            end
          end
        end
        PERM: begin
          if (perm_done) begin
            state <= EMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Directed bench for keccak_squeeze_serializer: lane order, last/done timing,
// permutation handshakes, backpressure and reset abort.
module tb_keccak_squeeze_serializer;

  localparam int RL = 17;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] out_len;
  logic [1599:0] state_in;
  logic          perm_req;
  logic          perm_done;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int epoch  = 0;

  keccak_squeeze_serializer #(.RATE_LANES(RL), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .out_len    (out_len),
    .state_in   (state_in),
    .perm_req   (perm_req),
    .perm_done  (perm_done),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Each lane encodes its permutation epoch and index, so a wrong lane or stale state is visible.
  function automatic logic [63:0] make_lane(input int ep, input int idx);
    return {16'hC0DE, ep[15:0], 32'h5A5A_0000 ^ idx[31:0]};
  endfunction

  function automatic logic [1599:0] make_state(input int ep);
    logic [1599:0] s;
    s = '0;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = make_lane(ep, i);
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one squeeze of len lanes, playing the permutation core and the downstream sink.
  task automatic applyStimulus(input int len, input bit random_ready, input int perm_delay);
    int hs, perms, cycles, perm_wait, base;
    bit prev_stall, prev_perm_done, finished;
    logic [63:0] held_dout;
    logic held_last;
    hs = 0; perms = 0; cycles = 0; perm_wait = perm_delay; base = epoch;
    prev_stall = 1'b0; prev_perm_done = 1'b0; finished = 1'b0;
    held_dout = '0; held_last = 1'b0;
    start = 1'b1; out_len = LW'(len); dout_ready = 1'b0;
    stepCycle();
    start = 1'b0;
    while (!finished && cycles < 3000) begin
      cycles++;
      perm_done  = 1'b0;
      dout_ready = 1'b0;
      if (prev_perm_done) begin
        checkOutput("perm_req_drop", 64'(perm_req), 64'd0);
        checkOutput("emit_after_perm", 64'(dout_valid), 64'd1);
      end
      prev_perm_done = 1'b0;
      if (hs == len) begin
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        checkOutput("valid_at_done", 64'(dout_valid), 64'd0);
        finished = 1'b1;
      end else if (perm_req) begin
        checkOutput("valid_in_perm", 64'(dout_valid), 64'd0);
        if (perm_wait == 0) begin
          epoch++;
          state_in = make_state(epoch);
          perm_done = 1'b1;
          perms++;
          perm_wait = perm_delay;
          prev_perm_done = 1'b1;
        end else begin
          perm_wait--;
        end
      end else begin
        checkOutput("valid_in_emit", 64'(dout_valid), 64'd1);
        checkOutput("lane_data", dout, make_lane(base + hs / RL, hs % RL));
        checkOutput("last_flag", 64'(last), 64'(hs == len - 1));
        checkOutput("done_early", 64'(done), 64'd0);
        if (prev_stall) begin
          checkOutput("stall_dout", dout, held_dout);
          checkOutput("stall_last", 64'(last), 64'(held_last));
        end
        dout_ready = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        prev_stall = !dout_ready;
        held_dout  = dout;
        held_last  = last;
        if (dout_ready) hs++;
      end
      if (!finished) stepCycle();
    end
    if (!finished) checkOutput("timeout", 64'd1, 64'd0);
    checkOutput("handshakes", 64'(hs), 64'(len));
    checkOutput("perm_count", 64'(perms), 64'((len - 1) / RL));
    dout_ready = 1'b0;
    stepCycle();
    checkOutput("done_cleared", 64'(done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; perm_done = 1'b0; dout_ready = 1'b0; out_len = '0;
    state_in = make_state(0);
    stepCycle();
    stepCycle();
    checkOutput("rst_perm_req", 64'(perm_req), 64'd0);
    checkOutput("rst_valid", 64'(dout_valid), 64'd0);
    checkOutput("rst_last", 64'(last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_dout", dout, 64'd0);
    rst = 1'b0;
    stepCycle();

    applyStimulus(3, 1'b0, 5);
    applyStimulus(20, 1'b0, 5);
    applyStimulus(17, 1'b0, 5);

    // Zero-length request completes immediately without leaving IDLE.
    start = 1'b1; out_len = '0;
    stepCycle();
    start = 1'b0;
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    checkOutput("zero_valid", 64'(dout_valid), 64'd0);
    checkOutput("zero_perm", 64'(perm_req), 64'd0);
    stepCycle();
    checkOutput("zero_done_clr", 64'(done), 64'd0);
    checkOutput("zero_busy_clr", 64'(busy), 64'd0);

    applyStimulus(40, 1'b1, 3);

    // Spurious start/perm_done while busy, then reset in the middle of a permutation.
    base = epoch;
    start = 1'b1; out_len = LW'(20); dout_ready = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (3) stepCycle();
    dout_ready = 1'b0; perm_done = 1'b1; start = 1'b1; out_len = LW'(2);
    stepCycle();
    perm_done = 1'b0; start = 1'b0;
    checkOutput("ign_valid", 64'(dout_valid), 64'd1);
    checkOutput("ign_lane", dout, make_lane(base, 3));
    checkOutput("ign_last", 64'(last), 64'd0);
    checkOutput("ign_perm", 64'(perm_req), 64'd0);
    dout_ready = 1'b1;
    repeat (14) stepCycle();
    dout_ready = 1'b0;
    checkOutput("perm_entered", 64'(perm_req), 64'd1);
    checkOutput("perm_valid", 64'(dout_valid), 64'd0);
    start = 1'b1; out_len = LW'(1);
    stepCycle();
    start = 1'b0;
    checkOutput("perm_start_ign", 64'(perm_req), 64'd1);
    checkOutput("perm_busy", 64'(busy), 64'd1);
    checkOutput("perm_done_out", 64'(done), 64'd0);
    rst = 1'b1; perm_done = 1'b1;
    stepCycle();
    rst = 1'b0; perm_done = 1'b0;
    checkOutput("abort_perm_req", 64'(perm_req), 64'd0);
    checkOutput("abort_valid", 64'(dout_valid), 64'd0);
    checkOutput("abort_last", 64'(last), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_dout", dout, 64'd0);
    stepCycle();
    checkOutput("abort_no_done", 64'(done), 64'd0);
    checkOutput("abort_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
